// File: rtl/encoder8to3_queue.sv
// rtl/encoder8to3_queue.sv - sequential 8-to-3 request encoder with sticky pending bits and valid/ready output
//
// Purpose:
//   Collects request strobes on 8 lines into a sticky pending register and
//   serializes them as 3-bit binary codes over a valid/ready handshake.
//   A loaded code is held stable until it is accepted.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   en         in   1  request capture enable (draining continues when 0)
//   req        in   8  request strobes, sampled each edge while en=1
//   out_code   out  3  binary index of the presented request
//   out_valid  out  1  out_code holds a valid request
//   out_ready  in   1  consumer accepts when out_valid && out_ready
//   pending    out  8  registered sticky pending vector (not yet presented)
//   merge      out  1  one-cycle pulse: a captured req bit was already pending
//
// Configuration:
//   ROUND_ROBIN_EN  defined   -> rotating-priority selection with pointer
//                   undefined -> fixed priority, lowest index first

module encoder8to3_queue (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [2:0] out_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] pending,
    output logic       merge
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [2:0] code_q, code_d;
    logic       merge_q, merge_d;

    logic [2:0] sel_idx;
    logic       load;
    logic [7:0] load_mask;
    logic [7:0] capture;

    // ------------------------------------------------------------------
    // Selection: works on the registered pending vector only, so a
    // request captured on an edge becomes eligible one edge later.
    // ------------------------------------------------------------------
`ifdef ROUND_ROBIN_EN
    logic [2:0] ptr_q, ptr_d;

    // Search upward from the pointer with wrap; iterating offsets from
    // high to low lets the smallest offset overwrite the result.
    always_comb begin
        logic [2:0] idx;
        sel_idx = 3'd0;
        idx     = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr_q + 3'(i);
            if (pending_q[idx]) begin
                sel_idx = idx;
            end
        end
    end

    // Pointer advances past the index just loaded (3-bit wrap 7 -> 0).
    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = sel_idx + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 3'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: lowest set index wins.
    always_comb begin
        sel_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_idx = 3'(i);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output FSM: next state, code load and load strobe.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pending_q != 8'h00) begin
                    load    = 1'b1;
                    code_d  = sel_idx;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                // Code stays frozen until accepted, even if a
                // higher-priority bit becomes pending meanwhile.
                if (out_ready) begin
                    if (pending_q != 8'h00) begin
                        load   = 1'b1;
                        code_d = sel_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pending register: clear the loaded bit, then OR in captures, so a
    // request arriving on its own load edge stays pending (set wins).
    // ------------------------------------------------------------------
    always_comb begin
        capture   = en ? req : 8'h00;
        load_mask = load ? (8'h01 << sel_idx) : 8'h00;
        pending_d = (pending_q & ~load_mask) | capture;
        // Only the pending register counts; a bit held solely in the
        // output stage does not merge.
        merge_d   = |(capture & pending_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= 8'h00;
            code_q    <= 3'd0;
            merge_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            merge_q   <= merge_d;
        end
    end

    assign out_valid = (state_q == ST_PRESENT);
    assign out_code  = code_q;
    assign pending   = pending_q;
    assign merge     = merge_q;

endmodule

// File: tb/tb_encoder8to3_queue.sv
// tb/tb_encoder8to3_queue.sv - self-checking bench for encoder8to3_queue with randomized stimulus

module tb_encoder8to3_queue;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [2:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pending;
    logic       merge;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] m_pending;
    logic       m_valid;
    logic [2:0] m_code;
    logic       m_merge;
    int         m_ptr;

    encoder8to3_queue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .merge     (merge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] p, input int start);
        for (int i = 0; i < 8; i++) begin
            if (p[(start + i) % 8]) return (start + i) % 8;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_pending = 8'h00;
        m_valid   = 1'b0;
        m_code    = 3'd0;
        m_merge   = 1'b0;
        m_ptr     = 0;
    endtask

    // One clock: drive inputs, advance the model across the edge, settle.
    task automatic step(input logic e, input logic [7:0] r, input logic rd);
        int         sel;
        int         start;
        logic       ld;
        logic [7:0] nxt;
        en = e; req = r; out_ready = rd;
        @(posedge clk);
`ifdef ROUND_ROBIN_EN
        start = m_ptr;
`else
        start = 0;
`endif
        sel = pick(m_pending, start);
        ld  = 1'b0;
        if (!m_valid || rd) begin
            if (m_pending != 8'h00) begin
                ld = 1'b1;
                m_code = 3'(sel);
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        nxt = m_pending;
        if (ld) nxt[sel] = 1'b0;
        if (e) nxt = nxt | r;
        m_merge = e && ((r & m_pending) != 8'h00);
        m_pending = nxt;
        if (ld) m_ptr = (sel + 1) % 8;
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 8'h00, 1'b1);
            checks++;
            if ({out_valid, (out_valid ? out_code : 3'd0), pending, merge} !==
                {m_valid, (m_valid ? m_code : 3'd0), m_pending, m_merge}) begin
                errors++;
                $display("FAIL drain: got v=%0b c=%0d p=%h m=%0b want v=%0b c=%0d p=%h m=%0b",
                         out_valid, out_code, pending, merge, m_valid, m_code, m_pending, m_merge);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; req = 8'h00; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_code, pending, merge} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b c=%0d p=%h m=%0b want all zero",
                     out_valid, out_code, pending, merge);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [2:0] exp_v;
        logic [2:0] got_v;
        step(1'b1, 8'h20, 1'b1);
        checks++;
        if (pending !== 8'h20 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_e0: got p=%h v=%0b want p=20 v=0", pending, out_valid);
        end
        step(1'b1, 8'h00, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_code !== 3'd5 || pending !== 8'h00) begin
            errors++;
            $display("FAIL single_e1: got v=%0b c=%0d p=%h want v=1 c=5 p=00", out_valid, out_code, pending);
        end
        step(1'b1, 8'h00, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_e2: got v=%0b want v=0", out_valid);
        end
        exp_v = 3'd0; got_v = 3'd0;
        drain(2);
    endtask

    task automatic test_burst();
        logic [2:0] got[$];
        step(1'b1, 8'h91, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b1);
            checks++;
            if ({out_valid, (out_valid ? out_code : 3'd0), pending} !==
                {m_valid, (m_valid ? m_code : 3'd0), m_pending}) begin
                errors++;
                $display("FAIL burst_model: got v=%0b c=%0d p=%h want v=%0b c=%0d p=%h",
                         out_valid, out_code, pending, m_valid, m_code, m_pending);
            end
            if (out_valid) got.push_back(out_code);
        end
`ifndef ROUND_ROBIN_EN
        checks++;
        if (got.size() != 3 || got[0] !== 3'd0 || got[1] !== 3'd4 || got[2] !== 3'd7) begin
            errors++;
            $display("FAIL burst_order: got %p want '{0,4,7}", got);
        end
`endif
        drain(2);
    endtask

    task automatic test_stall();
        step(1'b1, 8'h04, 1'b1);
        step(1'b1, 8'h01, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_code !== 3'd2) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%0b c=%0d want v=1 c=2", i, out_valid, out_code);
            end
            step(1'b0, 8'h00, 1'b0);
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_code !== 3'd0 || pending !== 8'h00) begin
            errors++;
            $display("FAIL stall_next: got v=%0b c=%0d p=%h want v=1 c=0 p=00", out_valid, out_code, pending);
        end
        drain(2);
    endtask

    task automatic test_merge();
        int n3;
        step(1'b1, 8'h09, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h08, 1'b0);
        checks++;
        if (merge !== 1'b1 || pending !== 8'h08) begin
            errors++;
            $display("FAIL merge_pulse: got m=%0b p=%h want m=1 p=08", merge, pending);
        end
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (merge !== 1'b0) begin
            errors++;
            $display("FAIL merge_clear: got m=%0b want m=0", merge);
        end
        n3 = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid && out_code == 3'd3) n3++;
            step(1'b0, 8'h00, 1'b1);
        end
        checks++;
        if (n3 != 1) begin
            errors++;
            $display("FAIL merge_once: got %0d presentations of code 3 want 1", n3);
        end
        step(1'b1, 8'h08, 1'b0);
        step(1'b1, 8'h08, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_code !== 3'd3 || pending !== 8'h08) begin
            errors++;
            $display("FAIL setwins: got v=%0b c=%0d p=%h want v=1 c=3 p=08", out_valid, out_code, pending);
        end
        n3 = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid && out_code == 3'd3) n3++;
            step(1'b0, 8'h00, 1'b1);
        end
        checks++;
        if (n3 != 2) begin
            errors++;
            $display("FAIL setwins_twice: got %0d presentations of code 3 want 2", n3);
        end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'hFF, 1'b1);
            checks++;
            if (pending !== 8'h00 || merge !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL enable_gate: got p=%h m=%0b v=%0b want p=00 m=0 v=0", pending, merge, out_valid);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h00, 1'b1);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL enable_idle: got v=%0b want v=0", out_valid);
            end
        end
    endtask

    task automatic test_reset_midpresent();
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'hF0, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || pending !== 8'hF0) begin
            errors++;
            $display("FAIL pre_reset: got v=%0b p=%h want v=1 p=F0", out_valid, pending);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({out_valid, out_code, pending, merge} !== 13'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%0b c=%0d p=%h m=%0b want all zero",
                     out_valid, out_code, pending, merge);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1);
            checks++;
            if (out_valid !== 1'b0 || pending !== 8'h00) begin
                errors++;
                $display("FAIL post_reset: got v=%0b p=%h want v=0 p=00", out_valid, pending);
            end
        end
    endtask

    task automatic test_random();
        logic       e;
        logic [7:0] r;
        logic       rd;
        for (int i = 0; i < 400; i++) begin
            e  = ($urandom_range(0, 4) != 0);
            r  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            rd = ($urandom_range(0, 3) != 0);
            step(e, r, rd);
            checks++;
            if ({out_valid, (out_valid ? out_code : 3'd0), pending, merge} !==
                {m_valid, (m_valid ? m_code : 3'd0), m_pending, m_merge}) begin
                errors++;
                $display("FAIL random%0d: got v=%0b c=%0d p=%h m=%0b want v=%0b c=%0d p=%h m=%0b",
                         i, out_valid, out_code, pending, merge, m_valid, m_code, m_pending, m_merge);
            end
        end
        drain(12);
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_stall();
        test_merge();
        test_enable();
        test_reset_midpresent();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
